// File: rtl/rdma_sq_credit_gate_pkg.sv
// Shared widths and the status bundle for the send-queue credit gate.
// Stage latency is 1 cycle on requests and 0 on ACKs; requests back-pressure when the register is full or credit runs out.
package rdma_sq_credit_gate_pkg;

  localparam int CRED_W = 8;
  localparam int STAT_W = 32;

  typedef struct packed {
    logic [CRED_W-1:0] outstanding;
    logic              stall;
    logic              tmo_flag;
    logic              unf_flag;
    logic [STAT_W-1:0] sent_cnt;
    logic [STAT_W-1:0] ack_cnt;
  } sq_gate_stat_t;

endpackage

// File: rtl/rdma_sq_wdog.sv
// ACK watchdog: counts idle cycles while requests are outstanding and sets a sticky flag at all-ones.
// The flag is a registered output with no data path, so there is no latency or back-pressure on traffic.
module rdma_sq_wdog #(
  parameter int TMO_W = 24
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic busy,
  input  logic kick,
  input  logic clr,
  output logic tmo_flag
);

  localparam logic [TMO_W-1:0] CNT_MAX = '1;
  localparam logic [TMO_W-1:0] CNT_PRE = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] cnt_q;
  logic             tmo_q;
  logic             hit;

  // Fires only on the step into all-ones, so a clear while saturated stays cleared.
  assign hit = busy && !kick && (cnt_q == CNT_PRE);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cnt_q <= '0;
    end else if (kick || !busy) begin
      cnt_q <= '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + TMO_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tmo_q <= 1'b0;
    end else if (hit) begin
      tmo_q <= 1'b1;
    end else if (clr) begin
      tmo_q <= 1'b0;
    end
  end

  assign tmo_flag = tmo_q;

endmodule

// File: rtl/rdma_sq_credit_gate.sv
// Per-region credit gate ahead of the RDMA send-queue arbiter: caps un-ACKed requests and supervises ACKs.
// Requests take 1 cycle through a single output register, and ACKs pass through combinationally.
module rdma_sq_credit_gate
  import rdma_sq_credit_gate_pkg::*;
#(
  parameter int N_OUTSTANDING = 32,
  parameter int SQ_W          = 256,
  parameter int ACK_W         = 32,
  parameter int TMO_W         = 24
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              s_sq_valid,
  output logic              s_sq_ready,
  input  logic [SQ_W-1:0]   s_sq_data,
  output logic              m_sq_valid,
  input  logic              m_sq_ready,
  output logic [SQ_W-1:0]   m_sq_data,
  input  logic              s_ack_valid,
  output logic              s_ack_ready,
  input  logic [ACK_W-1:0]  s_ack_data,
  output logic              m_ack_valid,
  input  logic              m_ack_ready,
  output logic [ACK_W-1:0]  m_ack_data,
  input  logic              clr_flags,
  output logic [CRED_W-1:0] outstanding,
  output logic              stall,
  output logic              tmo_flag,
  output logic              unf_flag,
  output logic [STAT_W-1:0] sent_cnt,
  output logic [STAT_W-1:0] ack_cnt
);

  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(N_OUTSTANDING);

  logic              sq_vld_q;
  logic [SQ_W-1:0]   sq_dat_q;
  logic [CRED_W-1:0] out_q;
  logic [CRED_W-1:0] out_d;
  logic              stall_q;
  logic              unf_q;
  logic [STAT_W-1:0] sent_q;
  logic [STAT_W-1:0] ack_q;
  logic              tmo;
  logic              accept;
  logic              ack_hs;
  logic              retire;
  logic              unf_set;
  sq_gate_stat_t     stat;

  assign s_sq_ready = (!sq_vld_q || m_sq_ready) && (out_q < CRED_MAX);
  assign accept     = s_sq_valid && s_sq_ready;

  assign m_ack_valid = s_ack_valid;
  assign s_ack_ready = m_ack_ready;
  assign m_ack_data  = s_ack_data;
  assign ack_hs      = s_ack_valid && m_ack_ready;

  // An ACK with nothing in flight is forwarded but cannot retire a credit.
  assign retire  = ack_hs && (out_q != '0);
  assign unf_set = ack_hs && (out_q == '0);

  always_comb begin
    out_d = out_q;
    case ({accept, retire})
      2'b10:   out_d = out_q + CRED_W'(1);
      2'b01:   out_d = out_q - CRED_W'(1);
      default: out_d = out_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sq_vld_q <= 1'b0;
      sq_dat_q <= '0;
    end else if (accept) begin
      sq_vld_q <= 1'b1;
      sq_dat_q <= s_sq_data;
    end else if (m_sq_ready) begin
      sq_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_q   <= '0;
      stall_q <= 1'b0;
      sent_q  <= '0;
      ack_q   <= '0;
    end else begin
      out_q   <= out_d;
      stall_q <= (out_d == CRED_MAX);
      if (accept) sent_q <= sent_q + STAT_W'(1);
      if (ack_hs) ack_q  <= ack_q + STAT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      unf_q <= 1'b0;
    end else if (unf_set) begin
      unf_q <= 1'b1;
    end else if (clr_flags) begin
      unf_q <= 1'b0;
    end
  end

  rdma_sq_wdog #(
    .TMO_W (TMO_W)
  ) u_wdog (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .busy     (out_q != '0),
    .kick     (ack_hs),
    .clr      (clr_flags),
    .tmo_flag (tmo)
  );

  assign stat = '{
    outstanding: out_q,
    stall:       stall_q,
    tmo_flag:    tmo,
    unf_flag:    unf_q,
    sent_cnt:    sent_q,
    ack_cnt:     ack_q
  };

  assign m_sq_valid  = sq_vld_q;
  assign m_sq_data   = sq_dat_q;
  assign outstanding = stat.outstanding;
  assign stall       = stat.stall;
  assign tmo_flag    = stat.tmo_flag;
  assign unf_flag    = stat.unf_flag;
  assign sent_cnt    = stat.sent_cnt;
  assign ack_cnt     = stat.ack_cnt;

endmodule

// File: tb/tb_rdma_sq_credit_gate.sv
// Bench for the credit gate: request data is scoreboarded from s_sq handshakes to m_sq handshakes.
module tb_rdma_sq_credit_gate;

  logic        aclk;
  logic        aresetn;
  logic        s_sq_valid;
  logic        s_sq_ready;
  logic [63:0] s_sq_data;
  logic        m_sq_valid;
  logic        m_sq_ready;
  logic [63:0] m_sq_data;
  logic        s_ack_valid;
  logic        s_ack_ready;
  logic [31:0] s_ack_data;
  logic        m_ack_valid;
  logic        m_ack_ready;
  logic [31:0] m_ack_data;
  logic        clr_flags;
  logic [7:0]  outstanding;
  logic        stall;
  logic        tmo_flag;
  logic        unf_flag;
  logic [31:0] sent_cnt;
  logic [31:0] ack_cnt;

  int n_chk  = 0;
  int n_pass = 0;
  logic [63:0] sq_q[$];

  rdma_sq_credit_gate #(
    .N_OUTSTANDING (4),
    .SQ_W          (64),
    .ACK_W         (32),
    .TMO_W         (4)
  ) dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .s_sq_valid  (s_sq_valid),
    .s_sq_ready  (s_sq_ready),
    .s_sq_data   (s_sq_data),
    .m_sq_valid  (m_sq_valid),
    .m_sq_ready  (m_sq_ready),
    .m_sq_data   (m_sq_data),
    .s_ack_valid (s_ack_valid),
    .s_ack_ready (s_ack_ready),
    .s_ack_data  (s_ack_data),
    .m_ack_valid (m_ack_valid),
    .m_ack_ready (m_ack_ready),
    .m_ack_data  (m_ack_data),
    .clr_flags   (clr_flags),
    .outstanding (outstanding),
    .stall       (stall),
    .tmo_flag    (tmo_flag),
    .unf_flag    (unf_flag),
    .sent_cnt    (sent_cnt),
    .ack_cnt     (ack_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  // Handshakes are stable at the falling edge and complete at the next rising edge.
  always @(negedge aclk) begin
    if (aresetn) begin
      if (m_sq_valid && m_sq_ready) begin
        if (sq_q.size() == 0) chk("m_sq_spurious", 64'(m_sq_valid), 64'd0);
        else chk("m_sq_data", m_sq_data, sq_q.pop_front());
      end
      if (s_sq_valid && s_sq_ready) sq_q.push_back(s_sq_data);
      if (s_ack_valid) chk("m_ack_data", 64'(m_ack_data), 64'(s_ack_data));
    end
  end

  initial begin
    int acc;
    aresetn     = 1'b0;
    s_sq_valid  = 1'b0;
    s_sq_data   = '0;
    m_sq_ready  = 1'b0;
    s_ack_valid = 1'b0;
    s_ack_data  = '0;
    m_ack_ready = 1'b0;
    clr_flags   = 1'b0;
    cyc(3);
    chk("rst_m_sq_valid", 64'(m_sq_valid), 64'd0);
    chk("rst_outstanding", 64'(outstanding), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_flags", 64'({tmo_flag, unf_flag}), 64'd0);
    chk("rst_cnts", 64'({sent_cnt, ack_cnt}), 64'd0);
    aresetn = 1'b1;
    #1;
    chk("rst_s_sq_ready", 64'(s_sq_ready), 64'd1);

    // Credit exhaustion: six offered, four fit.
    m_sq_ready = 1'b1;
    s_sq_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      s_sq_data = 64'hA0 + 64'(acc);
      #1;
      if (s_sq_ready) acc++;
      cyc(1);
    end
    chk("cred_accepted", 64'(acc), 64'd4);
    chk("cred_s_sq_ready", 64'(s_sq_ready), 64'd0);
    chk("cred_stall", 64'(stall), 64'd1);
    chk("cred_outstanding", 64'(outstanding), 64'd4);
    s_ack_valid = 1'b1;
    s_ack_data  = 32'hACC0_0001;
    m_ack_ready = 1'b1;
    #1;
    chk("ack_m_valid", 64'(m_ack_valid), 64'd1);
    chk("ack_s_ready", 64'(s_ack_ready), 64'd1);
    cyc(1);
    s_ack_valid = 1'b0;
    #1;
    chk("cred_ret_outstanding", 64'(outstanding), 64'd3);
    chk("cred_ret_s_sq_ready", 64'(s_sq_ready), 64'd1);
    cyc(1);
    s_sq_valid = 1'b0;
    #1;
    chk("fifth_outstanding", 64'(outstanding), 64'd4);
    chk("fifth_sent_cnt", 64'(sent_cnt), 64'd5);
    chk("fifth_ack_cnt", 64'(ack_cnt), 64'd1);
    s_ack_valid = 1'b1;
    s_ack_data  = 32'hACC0_0002;
    cyc(4);
    s_ack_valid = 1'b0;
    #1;
    chk("drain_outstanding", 64'(outstanding), 64'd0);
    chk("drain_stall", 64'(stall), 64'd0);

    // Back-pressure holds the output register.
    m_sq_ready = 1'b0;
    s_sq_valid = 1'b1;
    s_sq_data  = 64'h5555_AAAA_0000_0001;
    cyc(1);
    s_sq_data = 64'h5555_AAAA_0000_0002;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_m_valid", 64'(m_sq_valid), 64'd1);
      chk("bp_m_data", m_sq_data, 64'h5555_AAAA_0000_0001);
      chk("bp_s_ready", 64'(s_sq_ready), 64'd0);
      chk("bp_sent_cnt", 64'(sent_cnt), 64'd6);
      cyc(1);
    end
    s_sq_valid = 1'b0;
    m_sq_ready = 1'b1;
    cyc(1);
    chk("bp_drained", 64'(m_sq_valid), 64'd0);

    // Simultaneous accept and ACK at outstanding=2.
    s_sq_valid = 1'b1;
    s_sq_data  = 64'h3;
    cyc(1);
    chk("sim_pre_outstanding", 64'(outstanding), 64'd2);
    s_sq_data   = 64'h4;
    s_ack_valid = 1'b1;
    s_ack_data  = 32'hACC0_0003;
    cyc(1);
    s_sq_valid  = 1'b0;
    s_ack_valid = 1'b0;
    #1;
    chk("sim_outstanding", 64'(outstanding), 64'd2);
    chk("sim_sent_cnt", 64'(sent_cnt), 64'd8);
    chk("sim_ack_cnt", 64'(ack_cnt), 64'd6);
    s_ack_valid = 1'b1;
    cyc(2);
    s_ack_valid = 1'b0;
    #1;
    chk("sim_drain", 64'(outstanding), 64'd0);

    // Underflow ACK.
    s_ack_valid = 1'b1;
    s_ack_data  = 32'hDEAD_0001;
    #1;
    chk("unf_forwarded", 64'(m_ack_valid), 64'd1);
    cyc(1);
    s_ack_valid = 1'b0;
    #1;
    chk("unf_outstanding", 64'(outstanding), 64'd0);
    chk("unf_flag_set", 64'(unf_flag), 64'd1);
    chk("unf_ack_cnt", 64'(ack_cnt), 64'd9);
    clr_flags = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    #1;
    chk("unf_flag_clr", 64'(unf_flag), 64'd0);

    // Watchdog expiry 15 cycles after acceptance.
    s_sq_valid = 1'b1;
    s_sq_data  = 64'h5;
    cyc(1);
    s_sq_valid = 1'b0;
    cyc(14);
    chk("wd_before", 64'(tmo_flag), 64'd0);
    cyc(1);
    chk("wd_fire", 64'(tmo_flag), 64'd1);
    chk("wd_no_reclaim", 64'(outstanding), 64'd1);
    s_ack_valid = 1'b1;
    cyc(1);
    s_ack_valid = 1'b0;
    clr_flags   = 1'b1;
    cyc(1);
    clr_flags = 1'b0;
    #1;
    chk("wd_clr", 64'(tmo_flag), 64'd0);

    // ACK in the last idle cycle keeps the flag clear.
    s_sq_valid = 1'b1;
    s_sq_data  = 64'h6;
    cyc(1);
    s_sq_valid = 1'b0;
    cyc(14);
    s_ack_valid = 1'b1;
    cyc(1);
    s_ack_valid = 1'b0;
    #1;
    chk("wd_kick", 64'(tmo_flag), 64'd0);
    cyc(5);
    chk("wd_kick_hold", 64'(tmo_flag), 64'd0);

    // Reset mid-operation with a held request and unf set.
    s_ack_valid = 1'b1;
    cyc(1);
    s_ack_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s_sq_valid = 1'b1;
      s_sq_data  = 64'h10 + 64'(i);
      cyc(1);
    end
    s_sq_valid = 1'b0;
    m_sq_ready = 1'b0;
    #1;
    chk("mid_outstanding", 64'(outstanding), 64'd3);
    chk("mid_m_valid", 64'(m_sq_valid), 64'd1);
    chk("mid_unf", 64'(unf_flag), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_valid", 64'(m_sq_valid), 64'd0);
    chk("mid_rst_m_data", m_sq_data, 64'd0);
    chk("mid_rst_outstanding", 64'(outstanding), 64'd0);
    chk("mid_rst_stall", 64'(stall), 64'd0);
    chk("mid_rst_flags", 64'({tmo_flag, unf_flag}), 64'd0);
    chk("mid_rst_cnts", 64'({sent_cnt, ack_cnt}), 64'd0);
    sq_q.delete();
    cyc(2);
    aresetn = 1'b1;
    #1;
    chk("mid_rel_s_ready", 64'(s_sq_ready), 64'd1);
    chk("sb_empty", 64'(sq_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
